// File: rtl/preif_stage_pkg.sv
// Shared definitions for the pre-IF fetch stage: reset PC, FSM encoding,
// and the layout of the slot bus handed to IF.
package preif_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h1C00_0000;
  localparam logic [1:0]  CANCEL_MAX = 2'd2;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT_IF = 2'd1,
    ST_ABORT   = 2'd2
  } preif_state_e;

  // Slot bus to IF: {adef, req, line2_valid, pc}
  localparam int PREIF_TO_IF_W = 35;
  localparam int PTI_PC_LSB    = 0;
  localparam int PTI_LINE2_BIT = 32;
  localparam int PTI_REQ_BIT   = 33;
  localparam int PTI_ADEF_BIT  = 34;

  // Next sequential fetch pair: 8-byte aligned successor.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return {pc[31:3] + 29'd1, 3'b000};
  endfunction

endpackage

// File: rtl/preif_cancel_cnt.sv
// Counts cancelled in-flight fetches and swallows their data_ok returns so
// IF only ever sees data for slots it actually accepted.
module preif_cancel_cnt
  import preif_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_data_ok,
  output logic [1:0] o_cnt,
  output logic       o_data_ok
);

  logic [1:0] r_cnt;
  logic       w_dec;

  assign w_dec = i_data_ok && (r_cnt != 2'd0);

  // Saturating up/down counter; a simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
    end else if (i_inc && !w_dec) begin
      r_cnt <= (r_cnt == CANCEL_MAX) ? CANCEL_MAX : r_cnt + 2'd1;
    end else if (w_dec && !i_inc) begin
      r_cnt <= r_cnt - 2'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_data_ok = i_data_ok && (r_cnt == 2'd0) && !rst;

endmodule

// File: rtl/preif_stage.sv
// Pre-IF stage: picks the next fetch PC, issues the instruction-SRAM
// request and presents one fetch slot to IF, handling redirects mid-flight.
module preif_stage
  import preif_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_allowin_i,
  output logic        preif_to_if_valid_o,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_pc_i,
  input  logic        banch_flush_i,
  input  logic [31:0] banch_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  output logic        inst_sram_req_o,
  output logic [31:0] inst_sram_addr_o,
  input  logic        inst_sram_addr_ok_i,
  input  logic        inst_sram_data_ok_i,
  output logic        inst_sram_data_ok_o,
  output logic [31:0] to_if_pc_o,
  output logic        to_if_line2_valid_o,
  output logic        to_if_req_o,
  output logic        to_if_adef_o
);

  preif_state_e r_state;
  preif_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_redir_pc;
  logic [31:0]  w_redir_pc_nxt;
  logic         w_cancel_inc;
  logic [1:0]   w_cancel_cnt;
  logic         w_adef;
  logic         w_req;
  logic         w_accept;
  logic         w_valid;
  logic         w_xfer;
  logic         w_redir;
  logic [31:0]  w_redir_tgt;
  logic [31:0]  w_next_pc;
  logic [PREIF_TO_IF_W-1:0] w_bus;

  assign w_adef      = (r_pc[1:0] != 2'b00);
  assign w_redir     = excep_flush_i | banch_flush_i;
  assign w_redir_tgt = excep_flush_i ? excep_pc_i : banch_pc_i;
  // ABORT keeps the original request up until the SRAM takes it.
  assign w_req       = (r_state == ST_ABORT) ||
                       ((r_state == ST_REQ) && !w_adef && (w_cancel_cnt != CANCEL_MAX));
  assign w_accept    = w_req && inst_sram_addr_ok_i;
  assign w_valid     = (r_state == ST_WAIT_IF) ||
                       ((r_state == ST_REQ) && (w_accept || w_adef));
  assign w_xfer      = w_valid && if_allowin_i;
  assign w_next_pc   = w_redir ? w_redir_tgt : (pred_taken_i ? pred_pc_i : seq_pc(r_pc));

  // Next-state, next-PC and cancellation decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_cancel_inc   = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (w_xfer) begin
          w_pc_nxt = w_next_pc;
        end else if (w_valid) begin
          if (w_redir) begin
            w_pc_nxt     = w_redir_tgt;
            w_cancel_inc = w_accept;
          end else begin
            w_state_nxt = ST_WAIT_IF;
          end
        end else if (w_redir) begin
          // A request still on the bus must be retired before refetching.
          if (w_req) begin
            w_redir_pc_nxt = w_redir_tgt;
            w_state_nxt    = ST_ABORT;
          end else begin
            w_pc_nxt = w_redir_tgt;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT_IF: begin
        if (w_xfer) begin
          w_pc_nxt    = w_next_pc;
          w_state_nxt = ST_REQ;
        end else if (w_redir) begin
          w_pc_nxt     = w_redir_tgt;
          w_cancel_inc = !w_adef;
          w_state_nxt  = ST_REQ;
        end else begin
          w_state_nxt = ST_WAIT_IF;
        end
      end
      ST_ABORT: begin
        if (inst_sram_addr_ok_i) begin
          w_cancel_inc = 1'b1;
          w_pc_nxt     = w_redir ? w_redir_tgt : r_redir_pc;
          w_state_nxt  = ST_REQ;
        end else if (w_redir) begin
          w_redir_pc_nxt = w_redir_tgt;
        end else begin
          w_state_nxt = ST_ABORT;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_redir_pc <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  preif_cancel_cnt u_cancel_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_cancel_inc),
    .i_data_ok (inst_sram_data_ok_i),
    .o_cnt     (w_cancel_cnt),
    .o_data_ok (inst_sram_data_ok_o)
  );

  assign w_bus = {w_adef, !w_adef, !r_pc[2], r_pc};

  assign preif_to_if_valid_o = w_valid && !rst;
  assign inst_sram_req_o     = w_req && !rst;
  assign inst_sram_addr_o    = rst ? 32'h0000_0000 : {r_pc[31:3], 3'b000};
  assign to_if_pc_o          = rst ? 32'h0000_0000 : w_bus[PTI_PC_LSB +: 32];
  assign to_if_line2_valid_o = w_bus[PTI_LINE2_BIT] && !rst;
  assign to_if_req_o         = w_bus[PTI_REQ_BIT] && !rst;
  assign to_if_adef_o        = w_bus[PTI_ADEF_BIT] && !rst;

endmodule

// File: tb/tb_preif_stage.sv
// Bench for preif_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_preif_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_allowin_i = 1'b0;
  logic        preif_to_if_valid_o;
  logic        excep_flush_i = 1'b0;
  logic [31:0] excep_pc_i = 32'h0;
  logic        banch_flush_i = 1'b0;
  logic [31:0] banch_pc_i = 32'h0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_pc_i = 32'h0;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i = 1'b0;
  logic        inst_sram_data_ok_i = 1'b0;
  logic        inst_sram_data_ok_o;
  logic [31:0] to_if_pc_o;
  logic        to_if_line2_valid_o;
  logic        to_if_req_o;
  logic        to_if_adef_o;

  int total = 0;
  int bad   = 0;

  preif_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_allowin_i        (if_allowin_i),
    .preif_to_if_valid_o (preif_to_if_valid_o),
    .excep_flush_i       (excep_flush_i),
    .excep_pc_i          (excep_pc_i),
    .banch_flush_i       (banch_flush_i),
    .banch_pc_i          (banch_pc_i),
    .pred_taken_i        (pred_taken_i),
    .pred_pc_i           (pred_pc_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_sram_data_ok_o (inst_sram_data_ok_o),
    .to_if_pc_o          (to_if_pc_o),
    .to_if_line2_valid_o (to_if_line2_valid_o),
    .to_if_req_o         (to_if_req_o),
    .to_if_adef_o        (to_if_adef_o)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the slot is either being fetched, parked for IF, or its fetch is
  // being aborted; cancelled fetches still owe one data return each.
  logic [31:0] m_pc;
  logic [31:0] m_abort_pc;
  bit          m_slot;
  bit          m_abort;
  int          m_cancel;

  always @(negedge clk) begin : model
    bit          adef;
    bit          issue;
    bit          present;
    bit          redir;
    logic [31:0] tgt;
    int          nc;
    if (rst) begin
      chk1("rst_valid", preif_to_if_valid_o, 1'b0);
      chk1("rst_req", inst_sram_req_o, 1'b0);
      chk32("rst_addr", inst_sram_addr_o, 32'h0);
      chk1("rst_dok", inst_sram_data_ok_o, 1'b0);
      chk32("rst_pc", to_if_pc_o, 32'h0);
      chk1("rst_line2", to_if_line2_valid_o, 1'b0);
      chk1("rst_ifreq", to_if_req_o, 1'b0);
      chk1("rst_adef", to_if_adef_o, 1'b0);
      m_pc = 32'h1C00_0000; m_abort_pc = 32'h0;
      m_slot = 1'b0; m_abort = 1'b0; m_cancel = 0;
    end else begin
      adef    = (m_pc[1:0] != 2'b00);
      issue   = !m_slot && (m_abort || (!adef && m_cancel < 2));
      present = m_slot || (!m_abort && (adef || (issue && inst_sram_addr_ok_i)));
      chk1("m_valid", preif_to_if_valid_o, present);
      chk1("m_req", inst_sram_req_o, issue);
      if (issue) chk32("m_addr", inst_sram_addr_o, m_pc & 32'hFFFF_FFF8);
      chk1("m_dok", inst_sram_data_ok_o, inst_sram_data_ok_i && m_cancel == 0);
      if (present) begin
        chk32("m_pc", to_if_pc_o, m_pc);
        chk1("m_line2", to_if_line2_valid_o, !m_pc[2]);
        chk1("m_ifreq", to_if_req_o, !adef);
        chk1("m_adef", to_if_adef_o, adef);
      end
      redir = excep_flush_i || banch_flush_i;
      tgt   = excep_flush_i ? excep_pc_i : banch_pc_i;
      nc    = m_cancel - ((inst_sram_data_ok_i && m_cancel > 0) ? 1 : 0);
      if (present && if_allowin_i) begin
        m_pc   = redir ? tgt : (pred_taken_i ? pred_pc_i : (m_pc & 32'hFFFF_FFF8) + 32'd8);
        m_slot = 1'b0;
      end else if (m_abort) begin
        if (inst_sram_addr_ok_i) begin
          nc = nc + 1;
          m_pc = redir ? tgt : m_abort_pc;
          m_abort = 1'b0;
        end else if (redir) begin
          m_abort_pc = tgt;
        end
      end else if (present) begin
        if (redir) begin
          nc = nc + (adef ? 0 : 1);
          m_pc = tgt;
          m_slot = 1'b0;
        end else begin
          m_slot = 1'b1;
        end
      end else if (redir) begin
        if (issue) begin
          m_abort = 1'b1;
          m_abort_pc = tgt;
        end else begin
          m_pc = tgt;
        end
      end
      m_cancel = (nc > 2) ? 2 : nc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    if_allowin_i = 1'b0; excep_flush_i = 1'b0; banch_flush_i = 1'b0;
    pred_taken_i = 1'b0; inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h1C00_0000 | ($urandom & 32'h0000_FFFC);
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  initial begin
    do_reset();

    // Straight-line fetch.
    if_allowin_i = 1'b1; inst_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    chk32("seq_a0", inst_sram_addr_o, 32'h1C00_0000);
    chk1("seq_l0", to_if_line2_valid_o, 1'b1);
    step();
    @(negedge clk);
    chk32("seq_a1", inst_sram_addr_o, 32'h1C00_0008);
    step();
    @(negedge clk);
    chk32("seq_a2", inst_sram_addr_o, 32'h1C00_0010);
    chk1("seq_l2", to_if_line2_valid_o, 1'b1);

    // Branch redirect while the request is pending.
    do_reset();
    banch_flush_i = 1'b1; banch_pc_i = 32'h1C00_0104;
    @(negedge clk);
    chk1("br_req0", inst_sram_req_o, 1'b1);
    step();
    banch_flush_i = 1'b0;
    @(negedge clk);
    chk32("br_hold", inst_sram_addr_o, 32'h1C00_0000);
    chk1("br_nvalid", preif_to_if_valid_o, 1'b0);
    step();
    inst_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    chk1("br_drop", preif_to_if_valid_o, 1'b0);
    step();
    inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b1;
    @(negedge clk);
    chk32("br_addr", inst_sram_addr_o, 32'h1C00_0100);
    chk1("br_line2", to_if_line2_valid_o, 1'b0);
    chk1("br_mask", inst_sram_data_ok_o, 1'b0);
    step();
    @(negedge clk);
    chk1("br_fwd", inst_sram_data_ok_o, 1'b1);
    step();

    // IF back-pressure.
    do_reset();
    inst_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    chk1("bp_v0", preif_to_if_valid_o, 1'b1);
    step();
    inst_sram_addr_ok_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("bp_hold", preif_to_if_valid_o, 1'b1);
      chk32("bp_pc", to_if_pc_o, 32'h1C00_0000);
      chk1("bp_noreq", inst_sram_req_o, 1'b0);
      step();
    end
    if_allowin_i = 1'b1;
    step();
    if_allowin_i = 1'b0;
    @(negedge clk);
    chk32("bp_next", inst_sram_addr_o, 32'h1C00_0008);
    chk1("bp_req", inst_sram_req_o, 1'b1);

    // Exception beats branch.
    do_reset();
    if_allowin_i = 1'b1; inst_sram_addr_ok_i = 1'b1;
    excep_flush_i = 1'b1; excep_pc_i = 32'h1C00_8000;
    banch_flush_i = 1'b1; banch_pc_i = 32'h1C00_0200;
    step();
    clear_in();
    @(negedge clk);
    chk32("pri_addr", inst_sram_addr_o, 32'h1C00_8000);

    // Misaligned target gives an ADEF slot without a request.
    do_reset();
    if_allowin_i = 1'b1; inst_sram_addr_ok_i = 1'b1;
    excep_flush_i = 1'b1; excep_pc_i = 32'h1C00_0002;
    step();
    clear_in();
    @(negedge clk);
    chk1("adef_noreq", inst_sram_req_o, 1'b0);
    chk1("adef_valid", preif_to_if_valid_o, 1'b1);
    chk1("adef_flag", to_if_adef_o, 1'b1);
    chk1("adef_ifreq", to_if_req_o, 1'b0);
    step();
    banch_flush_i = 1'b1; banch_pc_i = 32'h1C00_0300;
    step();
    clear_in();
    inst_sram_data_ok_i = 1'b1;
    @(negedge clk);
    chk1("adef_nocancel", inst_sram_data_ok_o, 1'b1);
    chk32("adef_re", inst_sram_addr_o, 32'h1C00_0300);
    step();

    // Two cancellations block requests until a data return drains one.
    do_reset();
    inst_sram_addr_ok_i = 1'b1; banch_flush_i = 1'b1; banch_pc_i = 32'h1C00_0400;
    step();
    banch_pc_i = 32'h1C00_0500;
    step();
    clear_in();
    @(negedge clk);
    chk1("c2_block0", inst_sram_req_o, 1'b0);
    step();
    inst_sram_data_ok_i = 1'b1;
    @(negedge clk);
    chk1("c2_block1", inst_sram_req_o, 1'b0);
    chk1("c2_mask", inst_sram_data_ok_o, 1'b0);
    step();
    inst_sram_data_ok_i = 1'b0;
    @(negedge clk);
    chk1("c2_resume", inst_sram_req_o, 1'b1);
    chk32("c2_addr", inst_sram_addr_o, 32'h1C00_0500);
    step();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      rst                 = ($urandom_range(0, 299) == 0);
      if_allowin_i        = ($urandom_range(0, 9) < 7);
      inst_sram_addr_ok_i = ($urandom_range(0, 1) == 1);
      inst_sram_data_ok_i = ($urandom_range(0, 9) < 3);
      excep_flush_i       = ($urandom_range(0, 19) == 0);
      banch_flush_i       = ($urandom_range(0, 9) == 0);
      pred_taken_i        = ($urandom_range(0, 4) == 0);
      excep_pc_i          = rand_pc();
      banch_pc_i          = rand_pc();
      pred_pc_i           = rand_pc();
      step();
    end
    clear_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
